// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    // Word index to word-aligned byte address.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream MSB-first into 32-bit words.
// `full` flags the shift that completes a word; `word` is the completed
// word presented combinationally on that same cycle.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    localparam int unsigned CNT_W  = $clog2(WORD_BYTES);
    localparam int unsigned PART_W = (WORD_BYTES - 1) * 8;

    logic [CNT_W-1:0]  cnt;
    logic [PART_W-1:0] partial;

    // Shift register of the bytes received so far plus a wrapping byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            partial <= '0;
        end else if (clr) begin
            cnt     <= '0;
            partial <= '0;
        end else if (shift_en) begin
            cnt     <= cnt + 1'b1;
            partial <= {partial[PART_W-9:0], byte_in};
        end
    end

    assign word = {partial, byte_in};
    assign full = shift_en && (cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: clears the memory, then writes
// length-prefixed, checksummed word data from a byte stream while holding
// the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
    localparam int unsigned LEN_W     = LEN_BYTES * 8;

    loader_state_t    state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] len_q;
    logic [7:0]       len_hi;
    logic [7:0]       csum;

    logic             accept;
    logic             idle_like;
    logic             begin_load;
    logic             shift_en;
    logic [31:0]      pk_word;
    logic             pk_full;
    logic [LEN_W-1:0] len_full;
    logic [IDX_W-1:0] idx_next;

    assign accept     = byte_valid && byte_ready;
    assign idle_like  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign begin_load = start && idle_like;
    assign shift_en   = accept && (state == S_DATA);
    assign len_full   = {len_hi, byte_data};
    assign idx_next   = idx + 1'b1;

    word_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (begin_load),
        .shift_en (shift_en),
        .byte_in  (byte_data),
        .word     (pk_word),
        .full     (pk_full)
    );

    // Load sequencer; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            len_q      <= '0;
            len_hi     <= '0;
            csum       <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state      <= S_CLEAR;
                        idx        <= '0;
                        csum       <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        imem_we    <= 1'b1;
                        imem_addr  <= '0;
                        imem_wdata <= NOP_WORD;
                    end
                end
                S_CLEAR: begin
                    if (idx == IDX_W'(MAX_WORDS - 1)) begin
                        state      <= S_LEN_HI;
                        idx        <= '0;
                        imem_we    <= 1'b0;
                        byte_ready <= 1'b1;
                    end else begin
                        idx       <= idx_next;
                        imem_addr <= word_addr(32'(idx_next));
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= byte_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_q <= IDX_W'(len_full);
                        if (len_full > LEN_W'(MAX_WORDS)) begin
                            state      <= S_ERR;
                            err        <= 1'b1;
                            busy       <= 1'b0;
                            byte_ready <= 1'b0;
                        end else if (len_full == '0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (pk_full) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= word_addr(32'(idx));
                            imem_wdata <= pk_word;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we    <= 1'b0;
                    idx        <= idx_next;
                    byte_ready <= 1'b1;
                    state      <= (idx_next == len_q) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (accept) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    imem_we    <= 1'b0;
                    cpu_hold   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of byte streams with expected
// outcome, a write scoreboard fed by a small stream model, and hand-written
// sequences for clear timing, write-cycle handshake, ignored start and reset.
module tb_imem_loader;

    localparam int unsigned MAXW = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [95:0] stream;   // right-aligned, first byte most significant
        int unsigned nbytes;
        logic        exp_done;
        logic        exp_err;
        bit          gaps;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[6];
    int   tests = 0;
    int   fails = 0;

    localparam logic [95:0] GOOD_STREAM = 96'h00_02_3C_01_12_34_34_21_56_78_20;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input vec_t v, input int unsigned i);
        logic [95:0] s;
        s = v.stream;
        return s[8*(v.nbytes-1-i) +: 8];
    endfunction

    // Scoreboard: every write the DUT makes must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected none", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    // Data writes implied by a stream: only when the length is legal.
    task automatic push_data_writes(input vec_t v);
        int unsigned n;
        n = {byte_at(v, 0), byte_at(v, 1)};
        if (n <= MAXW) begin
            for (int unsigned k = 0; k < n; k++) begin
                wr_t w;
                w.addr = 4 * k;
                w.data = {byte_at(v, 2+4*k), byte_at(v, 3+4*k), byte_at(v, 4+4*k), byte_at(v, 5+4*k)};
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic do_start();
        int unsigned cnt;
        for (int unsigned k = 0; k < MAXW; k++) begin
            wr_t w;
            w.addr = 4 * k;
            w.data = 32'h0;
            exp_q.push_back(w);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clr_first_we", {31'b0, imem_we}, 32'd1);
        check("clr_first_addr", imem_addr, 32'h0);
        check("clr_hold", {31'b0, cpu_hold}, 32'd1);
        cnt = 0;
        while (!byte_ready && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("clr_cycles", cnt, 32'd1024);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned cnt;
        for (int unsigned g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        cnt = 0;
        while (!byte_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic finish_checks(input string name, input logic exp_done, input logic exp_err);
        check({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({name, "_hold"}, {31'b0, cpu_hold}, {31'b0, exp_err});
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        check({name, "_ready_after"}, {31'b0, byte_ready}, 32'd0);
        byte_valid = 1'b0;
        check({name, "_writes_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_case(input vec_t v);
        do_start();
        push_data_writes(v);
        for (int unsigned i = 0; i < v.nbytes; i++)
            send_byte(byte_at(v, i), v.gaps ? $urandom_range(0, 3) : 0);
        finish_checks(v.name, v.exp_done, v.exp_err);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {26'b0, byte_ready, imem_we, cpu_hold, busy, done, err}, 32'd0);
        check({name, "_addr"}, imem_addr, 32'h0);
        check({name, "_wdata"}, imem_wdata, 32'h0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"good",      GOOD_STREAM,                               11, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"bad_csum",  96'h00_02_3C_01_12_34_34_21_56_78_21,      11, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"empty",     96'h00_00_00,                              3,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{"oversize",  96'h04_01,                                 2,  1'b0, 1'b1, 1'b0};
        vecs[4] = '{"good_gaps", GOOD_STREAM,                               11, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"one_word",  96'h00_01_AA_BB_CC_DD_00,                  7,  1'b1, 1'b0, 1'b1};

        // Reset with random inputs toggling.
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start      = 1'($urandom);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
        end
        check_all_zero("reset");
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b1;
        rst_n      = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle_offer");
        byte_valid = 1'b0;

        for (int i = 0; i < 6; i++)
            run_case(vecs[i]);

        // Write cycle handshake and start ignored while busy.
        begin
            vec_t v;
            v = vecs[0];
            do_start();
            push_data_writes(v);
            for (int unsigned i = 0; i < 3; i++)
                send_byte(byte_at(v, i), 0);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_busy_ignored", {30'b0, busy, byte_ready}, 32'd3);
            for (int unsigned i = 3; i < 6; i++)
                send_byte(byte_at(v, i), 0);
            check("write_we", {30'b0, imem_we, byte_ready}, 32'd2);
            check("write_addr", imem_addr, 32'h0);
            check("write_data", imem_wdata, 32'h3C01_1234);
            @(posedge clk);
            #1;
            check("write_ready_back", {30'b0, imem_we, byte_ready}, 32'd1);
            for (int unsigned i = 6; i < v.nbytes; i++)
                send_byte(byte_at(v, i), 0);
            finish_checks("start_mid", 1'b1, 1'b0);
        end

        // Asynchronous reset mid-DATA, then a full good load.
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h01, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_case(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time programming engine for the instruction memory. It accepts a byte stream over a valid/ready handshake and clears the whole instruction memory to `0x00000000` (nop). It then packs incoming bytes MSB-first into 32-bit instruction words and drives the instruction memory's write port. While loading it holds the CPU in reset via `cpu_hold`. It sits between a byte source (UART receiver or testbench) and the write side of the instruction store.

## Interface
- `ADDR_W`, 10: word-address width. Memory depth is `MAX_WORDS = 2**ADDR_W` = 1024.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts `byte_data` this cycle.
- `imem_we`  out  1  write strobe, one cycle per word.
- `imem_addr`  out  32  byte address, word-aligned (`{20'b0, word_idx, 2'b00}` for `ADDR_W`=10).
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keep the CPU in reset.
- `busy`  out  1  not in IDLE/DONE/ERR.
- `done`  out  1  last load succeeded; sticky until next `start`.
- `err`  out  1  last load failed; sticky until next `start`.

## Operation
- Handshake: a byte transfers on a rising edge with `byte_valid && byte_ready`. `byte_ready` depends only on state, never on `byte_valid`.
- Stream format:
  - Length: N, 16 bits, high byte then low byte.
  - Data: N words of 4 bytes each, MSB first.
  - Checksum: 1 byte, the XOR of all data bytes. Length bytes are excluded.
- States: IDLE, CLEAR, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR + `start` → CLEAR. This clears `done`, `err`, the checksum accumulator and the word index.
  - CLEAR: writes `0x00000000` to word indices 0..MAX_WORDS-1, one per cycle. After the last index → LEN_HI.
  - LEN_HI, then LEN_LO: one accepted byte each.
  - After LEN_LO:
    - N > MAX_WORDS → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accept 4 bytes, then → WRITE.
  - WRITE: one cycle with `imem_we`=1. Then → DATA if words remain, else → CSUM.
  - CSUM: one accepted byte. Match → DONE, mismatch → ERR.
- `byte_ready`=1 only in LEN_HI, LEN_LO, DATA and CSUM.
- `cpu_hold`=1 in CLEAR through CSUM and in ERR. It is 0 in IDLE and DONE.
- `start` is ignored while `busy`.
- Bytes offered in IDLE/DONE/ERR are not accepted.
- Addresses are never written beyond N-1. Words N..MAX_WORDS-1 remain nop from CLEAR.
- Word index and length arithmetic: unsigned. The index is `ADDR_W`+1 bits wide, so that N = MAX_WORDS is legal without wrap.

## Timing
- Reset values:
  - `byte_ready`, `imem_we`, `busy`, `done`, `err`, `cpu_hold`: 0.
  - `imem_addr`, `imem_wdata`: 0.
  - State: IDLE.
- `start` sampled at edge t:
  - CLEAR begins at t+1: `imem_we`=1 with `imem_addr`=0.
  - The last clear write (`imem_addr`=0xFFC) is at t+1024.
  - `byte_ready`=1 from t+1025.
- The 4th byte of word k is accepted at edge t:
  - WRITE at t+1 with `imem_addr`=4k; `byte_ready`=0 during that cycle.
  - `byte_ready`=1 again at t+2, or stays 0 if the next state is ERR.
- The checksum byte is accepted at edge t: `done` or `err` is 1 from t+1, and `cpu_hold` changes at t+1.
- Stalls: `byte_valid` may drop at any time. State and the partial word are held, with no timeout.
- Reset mid-operation: all outputs return to reset values immediately. The partially written memory is not repaired; a new `start` re-clears it.

## Structure
- Package `imem_loader_pkg`:
  - State enum `loader_state_t`.
  - `LEN_BYTES`=2, `WORD_BYTES`=4.
  - `NOP_WORD`=32'h00000000.
- Sub-module `word_packer`:
  - Inputs: byte shift-in, clear.
  - Outputs: `{word, full}` via a 2-bit byte counter.
  - The FSM and checksum stay in the top level.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → all outputs 0, state IDLE.
- Good load: `start`; stream 00 02 3C 01 12 34 34 21 56 78 20 →
  - 1024 zero writes to 0x000..0xFFC;
  - write 0x000=0x3C011234;
  - write 0x004=0x34215678;
  - `done`=1, `cpu_hold`=0.
- Bad checksum: same stream with a final byte of 21 → `err`=1, `done`=0, `cpu_hold`=1, and only the clear writes plus 2 data writes occurred.
- Empty and oversize length:
  - 00 00 00 → `done`, no data writes.
  - 04 01 → `err` after LEN_LO, `byte_ready`=0 thereafter.
- Stalls and ignored start: random `byte_valid` gaps on the good-load stream → identical write sequence. `start` pulsed during DATA → no effect.
- Reset mid-DATA, then `start` with the good-load stream → clean reset values, then the full good-load result.
